// File: rtl/rf_wb_arbiter_if.sv
// Writeback request bundle for the two sources sharing the register-file
// write port: req0 = ALU result, req1 = LSU load data.
interface rf_wb_arbiter_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            wb0_valid;
  logic            wb0_ready;
  logic [AW-1:0]   wb0_addr;
  logic [XLEN-1:0] wb0_data;
  logic            wb1_valid;
  logic            wb1_ready;
  logic [AW-1:0]   wb1_addr;
  logic [XLEN-1:0] wb1_data;

  // Writeback sources drive requests and observe the grant.
  modport master (
    output wb0_valid, wb0_addr, wb0_data,
    output wb1_valid, wb1_addr, wb1_data,
    input  wb0_ready, wb1_ready
  );

  // The arbiter consumes requests and returns the grant.
  modport slave (
    input  wb0_valid, wb0_addr, wb0_data,
    input  wb1_valid, wb1_addr, wb1_data,
    output wb0_ready, wb1_ready
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin between ALU and LSU results,
// one registered write per cycle, plus a busy scoreboard for RAW stalls.
module rf_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  rf_wb_arbiter_if.slave   wb,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rd,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             rf_wen,
  output logic [AW-1:0]    rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [NREG-1:0]  busy
);

  logic            rr_ptr;
  logic            gnt0, gnt1;
  logic            acc0, acc1;
  logic            both;
  logic [NREG-1:0] sb_set, sb_clr;

  // Grant: a lone requester always wins; on contention rr_ptr picks.
  // Ready is held low during reset so nothing is accepted then.
  always_comb begin
    both = wb.wb0_valid && wb.wb1_valid;
    gnt0 = wb.wb0_valid && (!wb.wb1_valid || !rr_ptr);
    gnt1 = wb.wb1_valid && (!wb.wb0_valid ||  rr_ptr);
    wb.wb0_ready = rst_n && gnt0;
    wb.wb1_ready = rst_n && gnt1;
    acc0 = wb.wb0_valid && wb.wb0_ready;
    acc1 = wb.wb1_valid && wb.wb1_ready;
  end

  // Round-robin pointer only moves on contention, toward the loser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rr_ptr <= 1'b0;
    else if (both) rr_ptr <= acc0;
  end

  // Output stage: drains every cycle. x0 targets are accepted but never
  // assert the write enable; address/data hold when nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (acc0) begin
      rf_wen   <= |wb.wb0_addr;
      rf_waddr <= wb.wb0_addr;
      rf_wdata <= wb.wb0_data;
    end else if (acc1) begin
      rf_wen   <= |wb.wb1_addr;
      rf_waddr <= wb.wb1_addr;
      rf_wdata <= wb.wb1_data;
    end else begin
      rf_wen   <= 1'b0;
    end
  end

  // Per-register set (issue) and clear (commit) strobes; x0 never sets.
  for (genvar i = 0; i < NREG; i++) begin : g_sb
    if (i == 0) begin : g_x0
      assign sb_set[i] = 1'b0;
    end else begin : g_xn
      assign sb_set[i] = issue_valid && (issue_rd == AW'(i));
    end
    assign sb_clr[i] = rf_wen && (rf_waddr == AW'(i));
  end

  // Scoreboard: clear at commit, set at issue, set wins on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= (busy & ~sb_clr) | sb_set;
  end

  // Hazard lookup for the decoder.
  always_comb begin
    rs1_busy = busy[rs1];
    rs2_busy = busy[rs2];
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter. Inputs change and outputs are sampled
// on the falling edge; the design updates on the rising edge.
module tb_rf_wb_arbiter;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk;
  logic            rst_n;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd, rs1, rs2;
  logic            rs1_busy, rs2_busy;
  logic            rf_wen;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [NREG-1:0] busy;

  int total = 0;
  int bad   = 0;

  rf_wb_arbiter_if #(.XLEN(XLEN), .AW(AW)) wb_if ();

  rf_wb_arbiter #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb         (wb_if.slave),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    wb_if.wb0_valid = 1'b0; wb_if.wb0_addr = '0; wb_if.wb0_data = '0;
    wb_if.wb1_valid = 1'b0; wb_if.wb1_addr = '0; wb_if.wb1_data = '0;
    issue_valid = 1'b0; issue_rd = '0; rs1 = '0; rs2 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    wb_if.wb0_valid = 1'b1; wb_if.wb0_addr = 5'd1; wb_if.wb0_data = 32'h11;
    wb_if.wb1_valid = 1'b1; wb_if.wb1_addr = 5'd2; wb_if.wb1_data = 32'h22;
    @(negedge clk);
    @(negedge clk);
    total++; if (wb_if.wb0_ready !== 1'b0) begin bad++; $display("FAIL rst_ready0 got=%b exp=0", wb_if.wb0_ready); end
    total++; if (wb_if.wb1_ready !== 1'b0) begin bad++; $display("FAIL rst_ready1 got=%b exp=0", wb_if.wb1_ready); end
    total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL rst_wen got=%b exp=0", rf_wen); end
    total++; if (busy !== '0) begin bad++; $display("FAIL rst_busy got=%h exp=0", busy); end
    total++; if (rf_waddr !== '0 || rf_wdata !== '0) begin bad++; $display("FAIL rst_wdat got=%0d/%h exp=0/0", rf_waddr, rf_wdata); end
    rst_n = 1'b1;
    #1;
    total++; if (wb_if.wb0_ready !== 1'b1 || wb_if.wb1_ready !== 1'b0) begin bad++; $display("FAIL rst_first_gnt got=%b%b exp=10", wb_if.wb0_ready, wb_if.wb1_ready); end
    @(negedge clk);
    total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd1) begin bad++; $display("FAIL rst_first_wr got=%b/%0d exp=1/1", rf_wen, rf_waddr); end
    idle_inputs();
  endtask

  task automatic test_single();
    do_reset();
    wb_if.wb1_valid = 1'b1; wb_if.wb1_addr = 5'd5; wb_if.wb1_data = 32'hDEADBEEF;
    #1;
    total++; if (wb_if.wb1_ready !== 1'b1 || wb_if.wb0_ready !== 1'b0) begin bad++; $display("FAIL single_ready got=%b%b exp=01", wb_if.wb0_ready, wb_if.wb1_ready); end
    @(negedge clk);
    total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wr got=%b/%0d/%h exp=1/5/deadbeef", rf_wen, rf_waddr, rf_wdata); end
    wb_if.wb1_valid = 1'b0;
    @(negedge clk);
    total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL single_idle_wen got=%b exp=0", rf_wen); end
    total++; if (rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_hold got=%0d/%h exp=5/deadbeef", rf_waddr, rf_wdata); end
  endtask

  task automatic test_contention();
    logic [AW-1:0]   exp_a [4];
    logic [XLEN-1:0] exp_d [4];
    exp_a[0] = 5'd1; exp_a[1] = 5'd2; exp_a[2] = 5'd1; exp_a[3] = 5'd2;
    exp_d[0] = 32'hA0; exp_d[1] = 32'hB0; exp_d[2] = 32'hA0; exp_d[3] = 32'hB0;
    do_reset();
    wb_if.wb0_valid = 1'b1; wb_if.wb0_addr = 5'd1; wb_if.wb0_data = 32'hA0;
    wb_if.wb1_valid = 1'b1; wb_if.wb1_addr = 5'd2; wb_if.wb1_data = 32'hB0;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (wb_if.wb0_ready !== ((k % 2) == 0) || wb_if.wb1_ready !== ((k % 2) == 1)) begin bad++; $display("FAIL cont_gnt%0d got=%b%b exp=%b%b", k, wb_if.wb0_ready, wb_if.wb1_ready, (k % 2) == 0, (k % 2) == 1); end
      @(negedge clk);
      total++; if (rf_wen !== 1'b1 || rf_waddr !== exp_a[k] || rf_wdata !== exp_d[k]) begin bad++; $display("FAIL cont_wr%0d got=%b/%0d/%h exp=1/%0d/%h", k, rf_wen, rf_waddr, rf_wdata, exp_a[k], exp_d[k]); end
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_x0();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd9;
    wb_if.wb0_valid = 1'b1; wb_if.wb0_addr = 5'd0; wb_if.wb0_data = 32'h1234;
    #1;
    total++; if (wb_if.wb0_ready !== 1'b1) begin bad++; $display("FAIL x0_ready got=%b exp=1", wb_if.wb0_ready); end
    @(negedge clk);
    idle_inputs();
    total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL x0_wen got=%b exp=0", rf_wen); end
    total++; if (busy !== 32'h0000_0200) begin bad++; $display("FAIL x0_busy got=%h exp=00000200", busy); end
    @(negedge clk);
    total++; if (rf_wen !== 1'b0 || busy !== 32'h0000_0200) begin bad++; $display("FAIL x0_after got=%b/%h exp=0/00000200", rf_wen, busy); end
  endtask

  task automatic test_scoreboard();
    do_reset();
    rs1 = 5'd7; rs2 = 5'd3;
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL sb_pre got=%b exp=0", rs1_busy); end
    @(negedge clk);
    issue_valid = 1'b0;
    total++; if (busy !== 32'h80 || rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin bad++; $display("FAIL sb_set got=%h/%b/%b exp=80/1/0", busy, rs1_busy, rs2_busy); end
    wb_if.wb0_valid = 1'b1; wb_if.wb0_addr = 5'd7; wb_if.wb0_data = 32'h77;
    @(negedge clk);
    wb_if.wb0_valid = 1'b0;
    total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd7 || busy[7] !== 1'b1) begin bad++; $display("FAIL sb_commit got=%b/%0d/%b exp=1/7/1", rf_wen, rf_waddr, busy[7]); end
    @(negedge clk);
    total++; if (busy[7] !== 1'b0 || rs1_busy !== 1'b0) begin bad++; $display("FAIL sb_clr got=%b/%b exp=0/0", busy[7], rs1_busy); end
    // Re-issue rd=7 on the very cycle a second write to x7 commits.
    wb_if.wb0_valid = 1'b1; wb_if.wb0_addr = 5'd7; wb_if.wb0_data = 32'h88;
    @(negedge clk);
    wb_if.wb0_valid = 1'b0;
    total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd7) begin bad++; $display("FAIL sb_commit2 got=%b/%0d exp=1/7", rf_wen, rf_waddr); end
    issue_valid = 1'b1; issue_rd = 5'd7;
    @(negedge clk);
    total++; if (busy !== 32'h80 || rs1_busy !== 1'b1) begin bad++; $display("FAIL sb_setwins got=%h/%b exp=80/1", busy, rs1_busy); end
    issue_rd = 5'd0; rs2 = 5'd0;
    @(negedge clk);
    issue_valid = 1'b0;
    total++; if (busy !== 32'h80 || rs2_busy !== 1'b0) begin bad++; $display("FAIL sb_x0 got=%h/%b exp=80/0", busy, rs2_busy); end
  endtask

  task automatic test_async_reset();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd3;
    wb_if.wb0_valid = 1'b1; wb_if.wb0_addr = 5'd3; wb_if.wb0_data = 32'h33;
    @(negedge clk);
    idle_inputs();
    total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd3 || busy !== 32'h8) begin bad++; $display("FAIL ar_pending got=%b/%0d/%h exp=1/3/8", rf_wen, rf_waddr, busy); end
    wb_if.wb0_valid = 1'b1; wb_if.wb0_addr = 5'd4;
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (rf_wen !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0) begin bad++; $display("FAIL ar_out got=%b/%0d/%h exp=0/0/0", rf_wen, rf_waddr, rf_wdata); end
    total++; if (busy !== '0 || wb_if.wb0_ready !== 1'b0) begin bad++; $display("FAIL ar_busy got=%h/%b exp=0/0", busy, wb_if.wb0_ready); end
    @(negedge clk);
    total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL ar_hold got=%b exp=0", rf_wen); end
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_x0();
    test_scoreboard();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
